// File: rtl/icache_refill.sv
// Fetches one cache line from instruction ROM a word per req/ack beat and hands it to the cache with a one-cycle strobe.
// Latency: LINE_WORDS ack edges after the miss is sampled. The ROM throttles through rom_ack, and misses are ignored while busy.
module icache_refill #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 16
) (
  input  logic                         sys_clk,
  input  logic                         sys_rst,
  input  logic                         miss_req,
  input  logic [ADDR_W-1:0]            miss_addr,
  output logic                         rom_req,
  output logic [ADDR_W-1:0]            rom_addr,
  input  logic                         rom_ack,
  input  logic [DATA_W-1:0]            rom_data,
  output logic [DATA_W*LINE_WORDS-1:0] refill_block,
  output logic [ADDR_W-$clog2(LINE_WORDS)-3:0] refill_tag,
  output logic                         refill_valid,
  output logic                         busy
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int TAG_W = ADDR_W - OFF_W - 2;
  localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [OFF_W-1:0] word_cnt;
  logic [OFF_W-1:0] word_nxt;
  logic [TAG_W-1:0] miss_tag;

  assign word_nxt = word_cnt + OFF_W'(1);
  assign miss_tag = miss_addr[ADDR_W-1 -: TAG_W];

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state        <= IDLE;
      word_cnt     <= '0;
      rom_req      <= 1'b0;
      rom_addr     <= '0;
      refill_block <= '0;
      refill_tag   <= '0;
      refill_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      refill_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (miss_req) begin
            refill_tag <= miss_tag;
            word_cnt   <= '0;
            rom_addr   <= {miss_tag, {OFF_W{1'b0}}, 2'b00};
            rom_req    <= 1'b1;
            busy       <= 1'b1;
            state      <= REQ;
          end
        end
        REQ: begin
          // rom_addr and rom_req stay put until the ROM acknowledges the beat
          if (rom_ack) begin
            refill_block[word_cnt*DATA_W +: DATA_W] <= rom_data;
            if (word_cnt == LAST_WORD) begin
              rom_req      <= 1'b0;
              refill_valid <= 1'b1;
              state        <= DONE;
            end else begin
              word_cnt <= word_nxt;
              rom_addr <= {refill_tag, word_nxt, 2'b00};
            end
          end
        end
        DONE: begin
          word_cnt <= '0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
